// File: rtl/serial_sub_16.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_16
// Purpose  : Multi-cycle subtractor. Computes diff = a - b - bin over WIDTH
//            bits, processing BPC bits per clock.
//
//            Each cycle handles one slice, least significant slice first.
//            The borrow ripples through the slice combinationally and is
//            held in a flop between cycles. Both sides of the block use a
//            valid/ready handshake.
//
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - operands and borrow-in valid
//            in_ready  - block can accept a new operation (IDLE)
//            a, b      - minuend, subtrahend (WIDTH bits)
//            bin       - borrow-in
//            out_valid - result valid (DONE)
//            out_ready - consumer accepts result
//            diff      - (a - b - bin) mod 2^WIDTH
//            bout      - borrow-out: 1 iff a < b + bin as unsigned
//            ovf       - signed overflow of a - b - bin
//            busy      - high while in RUN
//
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_16 #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = (BPC > 0) ? (WIDTH / BPC) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_bpc
      $error("serial_sub_16: BPC (%0d) must divide WIDTH (%0d) exactly", BPC, WIDTH);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sr;      // minuend, shifted right one slice per cycle
  logic [WIDTH-1:0] b_sr;      // subtrahend, shifted right one slice per cycle
  logic             a_msb;     // captured sign bits, needed for ovf after the
  logic             b_msb;     // originals have been shifted out
  logic             br;        // borrow carried between slices
  logic [CW-1:0]    cnt;       // index of the slice being processed
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;

  logic             last_slice;
  logic             accept;
  logic [BPC-1:0]   slice_d;
  logic             slice_br;
  logic             c;
  logic [WIDTH-1:0] slice_ext;

  assign last_slice = (cnt == CW'(N - 1));
  assign accept     = (state_q == IDLE) && in_valid;

  // --------------------------------------------------------------------------
  // Slice subtractor: borrow chains through the BPC bits of the current slice.
  // --------------------------------------------------------------------------
  always_comb begin
    slice_d = '0;
    c       = br;
    for (int i = 0; i < BPC; i++) begin
      slice_d[i] = a_sr[i] ^ b_sr[i] ^ c;
      c          = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & c);
    end
    slice_br = c;
  end

  // New slice enters at the top of the result register; after N shifts the
  // first (least significant) slice has reached bit 0.
  always_comb begin
    slice_ext                   = '0;
    slice_ext[WIDTH-1 -: BPC]   = slice_d;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only after the handshake; the next accept happens
        // no earlier than the following cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        br     <= bin;
        cnt    <= '0;
        diff_r <= '0;
        bout_r <= 1'b0;
        ovf_r  <= 1'b0;
      end else if (state_q == RUN) begin
        a_sr   <= a_sr >> BPC;
        b_sr   <= b_sr >> BPC;
        br     <= slice_br;
        diff_r <= (diff_r >> BPC) | slice_ext;
        if (last_slice) begin
          cnt    <= '0;
          bout_r <= slice_br;
          // Overflow only when operand signs differ and the result sign
          // differs from the minuend; slice_d[BPC-1] is the result MSB here.
          ovf_r  <= (a_msb ^ b_msb) & (slice_d[BPC-1] ^ a_msb);
        end else begin
          cnt    <= cnt + CW'(1);
        end
      end
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_16
// Purpose  : Self-checking bench for serial_sub_16. Three instances share the
//            operand inputs: BPC=1 (N=16), BPC=4 (N=4) and BPC=16 (N=1).
//            Each has its own handshake signals so they are exercised one at
//            a time. Directed vectors carry hand-computed results; the random
//            sweep uses an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        opbin;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  bout_v;
  logic [2:0]  ovf_v;
  logic [2:0]  busy_v;
  logic [15:0] diff_v [3];

  int errors = 0;
  int checks = 0;

  serial_sub_16 #(.WIDTH(16), .BPC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .diff(diff_v[0]), .bout(bout_v[0]),
    .ovf(ovf_v[0]), .busy(busy_v[0])
  );

  serial_sub_16 #(.WIDTH(16), .BPC(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .diff(diff_v[1]), .bout(bout_v[1]),
    .ovf(ovf_v[1]), .busy(busy_v[1])
  );

  serial_sub_16 #(.WIDTH(16), .BPC(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(opa), .b(opb), .bin(opbin), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .diff(diff_v[2]), .bout(bout_v[2]),
    .ovf(ovf_v[2]), .busy(busy_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int nv(input int idx);
    case (idx)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned 17-bit subtraction for diff/bout, signed range test
  // for overflow. Returns {ovf, bout, diff}.
  function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                        input logic bi);
    logic [16:0] u;
    int          s;
    logic        o;
    u = {1'b0, aa} - {1'b0, bb} - {16'd0, bi};
    s = int'($signed(aa)) - int'($signed(bb)) - int'(bi);
    o = (s > 32767) || (s < -32768);
    return {o, u[16], u[15:0]};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                      input logic bi);
    int w;
    w = 0;
    while (!in_ready_v[idx] && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready_v[idx]) check("send_timeout", 32'(in_ready_v[idx]), 32'd1);
    opa   = aa;
    opb   = bb;
    opbin = bi;
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
  endtask

  // k = edges after the accept edge until out_valid is seen; the consumer
  // first samples it at edge k+1.
  task automatic wait_done(input int idx, output int k);
    k = 0;
    while (!out_valid_v[idx] && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid_v[idx]) check("done_timeout", 32'(out_valid_v[idx]), 32'd1);
  endtask

  task automatic take(input int idx);
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                        input logic bi, input logic [15:0] ed, input logic eb,
                        input logic eo, input string tag);
    int k;
    send(idx, aa, bb, bi);
    wait_done(idx, k);
    check({tag, ".diff"}, 32'(diff_v[idx]), 32'(ed));
    check({tag, ".bout"}, 32'(bout_v[idx]), 32'(eb));
    check({tag, ".ovf"},  32'(ovf_v[idx]),  32'(eo));
    check({tag, ".lat"},  32'(k + 1),       32'(nv(idx) + 1));
    take(idx);
    check({tag, ".ready"}, 32'(in_ready_v[idx]),  32'd1);
    check({tag, ".oval"},  32'(out_valid_v[idx]), 32'd0);
  endtask

  task automatic throughput(input int idx);
    int  acc1;
    int  acc2;
    int  t;
    logic pre;
    acc1 = -1;
    acc2 = -1;
    opa = 16'h4321; opb = 16'h1111; opbin = 1'b0;
    in_valid_v[idx]  = 1'b1;
    out_ready_v[idx] = 1'b1;
    for (t = 1; t <= 3 * (nv(idx) + 2) + 4; t++) begin
      pre = in_ready_v[idx];
      @(posedge clk); #1;
      if (pre) begin
        if (acc1 < 0) acc1 = t;
        else if (acc2 < 0) acc2 = t;
      end
    end
    in_valid_v[idx] = 1'b0;
    repeat (nv(idx) + 4) @(posedge clk);
    #1;
    out_ready_v[idx] = 1'b0;
    check($sformatf("tput%0d.period", idx), 32'(acc2 - acc1), 32'(nv(idx) + 2));
    check($sformatf("tput%0d.diff", idx), 32'(diff_v[idx]), 32'h3210);
  endtask

  initial begin
    logic [17:0] m;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbi;
    int          k;

    rst_n = 1'b0;
    opa = '0; opb = '0; opbin = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready_v[0]),  32'd1);
    check("rst.out_valid", 32'(out_valid_v[0]), 32'd0);
    check("rst.busy",      32'(busy_v[0]),      32'd0);
    check("rst.diff",      32'(diff_v[0]),      32'd0);
    check("rst.bout_ovf",  32'({bout_v[0], ovf_v[0]}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic, borrow/wrap, signed overflow on BPC=1
    run_op(0, 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, "basic");
    run_op(0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "wrap0m1");
    run_op(0, 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, "wrapbin");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovfneg");
    run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovfpos");

    // Backpressure with ignored in_valid pulses in RUN and DONE
    send(0, 16'hA5A5, 16'h1111, 1'b0);
    opa = 16'hFFFF; opb = 16'h0000; opbin = 1'b1;
    in_valid_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    check("bp.busy", 32'(busy_v[0]), 32'd1);
    wait_done(0, k);
    for (int i = 0; i < 5; i++) begin
      in_valid_v[0] = i[0];
      opa = 16'(i * 16'h1357);
      check($sformatf("bp.diff%0d", i),  32'(diff_v[0]), 32'h9494);
      check($sformatf("bp.flags%0d", i), 32'({bout_v[0], ovf_v[0]}), 32'd0);
      check($sformatf("bp.rdy%0d", i),   32'(in_ready_v[0]), 32'd0);
      check($sformatf("bp.oval%0d", i),  32'(out_valid_v[0]), 32'd1);
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    check("bp.diff_end", 32'(diff_v[0]), 32'h9494);
    take(0);
    check("bp.release_rdy", 32'(in_ready_v[0]), 32'd1);

    // Reset mid-RUN at slice 7
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("mid.busy", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.in_ready",  32'(in_ready_v[0]),  32'd1);
    check("mid.out_valid", 32'(out_valid_v[0]), 32'd0);
    check("mid.busy0",     32'(busy_v[0]),      32'd0);
    check("mid.diff",      32'(diff_v[0]),      32'd0);
    check("mid.bout_ovf",  32'({bout_v[0], ovf_v[0]}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid.no_result", 32'(out_valid_v[0]), 32'd0);
    run_op(0, 16'h0010, 16'h0008, 1'b0, 16'h0008, 1'b0, 1'b0, "afterrst");

    // Parameter sweep: BPC=4 and BPC=16
    for (int idx = 1; idx <= 2; idx++) begin
      run_op(idx, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, $sformatf("p%0d.wrap", idx));
      run_op(idx, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, $sformatf("p%0d.ovf", idx));
      for (int n = 0; n < 1000; n++) begin
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rbi = 1'($urandom);
        m   = model(ra, rb, rbi);
        run_op(idx, ra, rb, rbi, m[15:0], m[16], m[17], $sformatf("p%0d.r%0d", idx, n));
      end
    end

    // Back-to-back throughput, out_ready held high
    throughput(0);
    throughput(1);
    throughput(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
